estagio_busca: RTL and testbench

Instruction-fetch (IF) stage that directly feeds instruction_memory. It holds the program counter and drives the word address `endereco` to the memory. It captures the returned `instrucao` into the IF/ID pipeline register consumed by decode. It handles pipeline stalls from hazard detection and PC redirects (branch/jump/call/ret) from execute, inserting a bubble on redirect.

---
 rtl/estagio_busca.sv | 62 ++++++
 tb/tb_estagio_busca.sv | 118 +++++++++++
 2 files changed

// File: rtl/estagio_busca.sv
// estagio_busca: instruction-fetch stage holding the PC and the IF/ID pipeline register
module estagio_busca #(
    parameter int unsigned TAM_MEM    = 32,
    parameter int unsigned PC_INICIAL = 0,
    parameter logic [31:0] INSTR_NOP  = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        parar,
    input  logic        desvio,
    input  logic [31:0] alvo_desvio,
    input  logic [31:0] instrucao,
    output logic [31:0] endereco,
    output logic [31:0] instrucao_id,
    output logic [31:0] pc_id,
    output logic        valido_id,
    output logic [31:0] contador_busca
);
    localparam int AW = $clog2(TAM_MEM);

    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_pc_id;
    logic [31:0]   r_instrucao_id;
    logic          r_valido_id;
    logic [31:0]   r_contador;
    logic [AW-1:0] w_pc_prox;
    logic [AW-1:0] w_alvo;
    logic          w_unused_alvo;

    // PC kept in AW bits so the +1 and the target truncation wrap modulo TAM_MEM for free
    assign w_pc_prox     = r_pc + AW'(1);
    assign w_alvo        = alvo_desvio[AW-1:0];
    assign w_unused_alvo = &{1'b0, alvo_desvio[31:AW]};

    assign endereco       = 32'(r_pc);
    assign instrucao_id   = r_instrucao_id;
    assign pc_id          = 32'(r_pc_id);
    assign valido_id      = r_valido_id;
    assign contador_busca = r_contador;

    // PC and IF/ID update: redirect beats stall, stall beats sequential fetch
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc           <= AW'(PC_INICIAL);
            r_pc_id        <= '0;
            r_instrucao_id <= INSTR_NOP;
            r_valido_id    <= 1'b0;
            r_contador     <= '0;
        end else if (desvio) begin
            r_pc           <= w_alvo;
            r_pc_id        <= '0;
            r_instrucao_id <= INSTR_NOP;
            r_valido_id    <= 1'b0;
        end else if (!parar) begin
            r_pc           <= w_pc_prox;
            r_pc_id        <= w_pc_prox;
            r_instrucao_id <= instrucao;
            r_valido_id    <= 1'b1;
            r_contador     <= r_contador + 32'd1;
        end
    end
endmodule

// File: tb/tb_estagio_busca.sv
// tb_estagio_busca: directed checks of fetch, stall, redirect, wrap and async reset
module tb_estagio_busca;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        parar = 1'b0;
    logic        desvio = 1'b0;
    logic [31:0] alvo_desvio = '0;
    logic [31:0] instrucao;
    logic [31:0] endereco;
    logic [31:0] instrucao_id;
    logic [31:0] pc_id;
    logic        valido_id;
    logic [31:0] contador_busca;
    int checks = 0;
    int failures = 0;

    estagio_busca dut (
        .clock(clock),
        .reset(reset),
        .parar(parar),
        .desvio(desvio),
        .alvo_desvio(alvo_desvio),
        .instrucao(instrucao),
        .endereco(endereco),
        .instrucao_id(instrucao_id),
        .pc_id(pc_id),
        .valido_id(valido_id),
        .contador_busca(contador_busca)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [4:0] a);
        return (a == 5'd31) ? 32'hFFFF_FFFF : (32'h1000_0000 | (32'(a) * 32'h0101));
    endfunction

    always_comb instrucao = mem_word(endereco[4:0]);

    task automatic verifica(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check_if(input string tag, input logic [31:0] e_end, input logic [31:0] e_ins,
                            input logic [31:0] e_pc, input logic e_val, input logic [31:0] e_cnt);
        verifica({tag, ".endereco"}, endereco, e_end);
        verifica({tag, ".instrucao_id"}, instrucao_id, e_ins);
        verifica({tag, ".pc_id"}, pc_id, e_pc);
        verifica({tag, ".valido_id"}, 32'(valido_id), 32'(e_val));
        verifica({tag, ".contador"}, contador_busca, e_cnt);
    endtask

    initial begin
        #1 reset = 1'b1;
        #1 check_if("reset_async", 32'd0, 32'h0, 32'd0, 1'b0, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            check_if($sformatf("fetch%0d", k), 32'(k), mem_word(5'(k - 1)), 32'(k), 1'b1, 32'(k));
        end
        parar = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_if($sformatf("stall%0d", k), 32'd3, mem_word(5'd2), 32'd3, 1'b1, 32'd3);
        end
        parar = 1'b0;
        step();
        check_if("stall_release", 32'd4, mem_word(5'd3), 32'd4, 1'b1, 32'd4);
        step();
        check_if("fetch5", 32'd5, mem_word(5'd4), 32'd5, 1'b1, 32'd5);
        desvio = 1'b1;
        alvo_desvio = 32'd12;
        step();
        check_if("redirect_bubble", 32'd12, 32'h0, 32'd0, 1'b0, 32'd5);
        desvio = 1'b0;
        step();
        check_if("redirect_target", 32'd13, mem_word(5'd12), 32'd13, 1'b1, 32'd6);
        desvio = 1'b1;
        parar = 1'b1;
        alvo_desvio = 32'd2;
        step();
        check_if("desvio_wins", 32'd2, 32'h0, 32'd0, 1'b0, 32'd6);
        parar = 1'b0;
        alvo_desvio = 32'd34;
        step();
        check_if("alvo_mod", 32'd2, 32'h0, 32'd0, 1'b0, 32'd6);
        desvio = 1'b0;
        step();
        check_if("after_mod", 32'd3, mem_word(5'd2), 32'd3, 1'b1, 32'd7);
        desvio = 1'b1;
        alvo_desvio = 32'd31;
        step();
        check_if("to31", 32'd31, 32'h0, 32'd0, 1'b0, 32'd7);
        desvio = 1'b0;
        step();
        check_if("wrap", 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'd8);
        for (int k = 0; k < 7; k++) step();
        check_if("run_to7", 32'd7, mem_word(5'd6), 32'd7, 1'b1, 32'd15);
        #2 reset = 1'b1;
        #1 check_if("mid_reset", 32'd0, 32'h0, 32'd0, 1'b0, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        check_if("reset_hold", 32'd0, 32'h0, 32'd0, 1'b0, 32'd0);
        step();
        check_if("resume", 32'd1, mem_word(5'd0), 32'd1, 1'b1, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
